// File: rtl/alu32_server_pkg.sv
// Shared ALU definitions: op codes, response record, FIFO depth.
package alu32_server_pkg;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef struct packed {
    logic [DATA_W-1:0] out;
    logic              overflow;
    logic              zero;
    logic              negative;
    logic              err;
  } rsp_t;

  // True for the six op codes the ALU implements.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SUB: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu32_server_alu32.sv
// 32-bit combinational ALU with overflow/zero/negative flags.
module alu32
  import alu32_server_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              overflow,
  output logic              zero,
  output logic              negative
);

  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic signed [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] diff;

  assign sa   = a;
  assign sb   = b;
  assign sum  = sa + sb;
  assign diff = sa - sb;

  // Select the operation; overflow is signed two's-complement overflow.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        overflow = (sa[DATA_W-1] == sb[DATA_W-1]) && (sum[DATA_W-1] != sa[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (sa[DATA_W-1] != sb[DATA_W-1]) && (diff[DATA_W-1] != sa[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    zero     = (result == '0);
    negative = result[DATA_W-1];
  end

endmodule

// File: rtl/alu32_server.sv
// Request/response wrapper around alu32: one operand stage (S1) feeding a
// 2-entry response FIFO, with an illegal-op counter.
module alu32_server
  import alu32_server_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_out,
  output logic        rsp_overflow,
  output logic        rsp_zero,
  output logic        rsp_negative,
  output logic        rsp_err,
  output logic [7:0]  err_count
);

  // Counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [2:0]        s1_op;

  logic [1:0]        fifo_count;
  logic              wr_ptr;
  logic              rd_ptr;
  rsp_t              fifo_mem [FIFO_DEPTH];

  logic              fifo_room;
  logic              accept;
  logic              advance;
  logic              pop;

  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              alu_zero;
  logic              alu_negative;
  rsp_t              push_rsp;
  rsp_t              head;

  // Ready depends only on registered state (and reset), never on rsp_ready/req_valid.
  assign fifo_room = (fifo_count < 2'(FIFO_DEPTH));
  assign req_ready = reset && (!s1_valid || fifo_room);
  assign accept    = req_valid && req_ready;
  assign advance   = s1_valid && fifo_room;
  assign pop       = rsp_valid && rsp_ready;

  // ---- stage S1: captured request ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a;
      s1_b     <= req_b;
      s1_op    <= req_op;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  alu32 u_alu (
    .a        (s1_a),
    .b        (s1_b),
    .op       (s1_op),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .negative (alu_negative)
  );

  // Build the response record; illegal ops report only the error flag.
  always_comb begin
    push_rsp = '0;
    if (op_legal(s1_op)) begin
      push_rsp.out      = alu_result;
      push_rsp.overflow = alu_overflow;
      push_rsp.zero     = alu_zero;
      push_rsp.negative = alu_negative;
    end else begin
      push_rsp.err      = 1'b1;
    end
  end

  // ---- stage S2: response FIFO ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (advance) begin
        fifo_mem[wr_ptr] <= push_rsp;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({advance, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Count accepted illegal ops, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (accept && !op_legal(req_op)) begin
      err_count <= sat_inc8(err_count);
    end
  end

  assign rsp_valid    = (fifo_count != 2'd0);
  assign head         = fifo_mem[rd_ptr];
  assign rsp_out      = rsp_valid ? head.out      : '0;
  assign rsp_overflow = rsp_valid ? head.overflow : 1'b0;
  assign rsp_zero     = rsp_valid ? head.zero     : 1'b0;
  assign rsp_negative = rsp_valid ? head.negative : 1'b0;
  assign rsp_err      = rsp_valid ? head.err      : 1'b0;

endmodule

// File: tb/tb_alu32_server.sv
// Self-checking bench for alu32_server: directed table, corner sequences,
// and randomized traffic against a scoreboard model.
module tb_alu32_server;
  import alu32_server_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_out;
  logic        rsp_overflow, rsp_zero, rsp_negative, rsp_err;
  logic [7:0]  err_count;

  alu32_server dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_negative (rsp_negative),
    .rsp_err      (rsp_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] out;
    logic        ov;
    logic        z;
    logic        n;
    logic        err;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  int   model_err = 0;
  int   errs_seen = 0;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the ALU rules evaluated with wide integer arithmetic.
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    vec_t   r;
    longint sa, sb, full;
    longint maxi;
    longint mini;
    maxi = 2147483647;
    mini = -maxi - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.a = a; r.b = b; r.op = op;
    r.out = 0; r.ov = 0; r.err = 0;
    case (op)
      ALU_ADD: begin full = sa + sb; r.out = a + b; r.ov = (full > maxi) || (full < mini); end
      ALU_SUB: begin full = sa - sb; r.out = a - b; r.ov = (full > maxi) || (full < mini); end
      ALU_AND: r.out = a & b;
      ALU_OR:  r.out = a | b;
      ALU_NOR: r.out = ~(a | b);
      ALU_XOR: r.out = a ^ b;
      default: r.err = 1;
    endcase
    r.z = !r.err && (r.out == 0);
    r.n = !r.err && r.out[31];
    return r;
  endfunction

  // Scoreboard: observe handshakes at negedge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      model_err = 0;
    end else begin
      chk("err_count", {24'b0, err_count}, model_err);
      if (rsp_valid && rsp_ready) begin
        chk("rsp_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          vec_t e;
          e = exp_q.pop_front();
          chk("sb_out", rsp_out, e.out);
          chk("sb_flags", {28'b0, rsp_overflow, rsp_zero, rsp_negative, rsp_err},
              {28'b0, e.ov, e.z, e.n, e.err});
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(model(req_a, req_b, req_op));
        if (!model(req_a, req_b, req_op).err == 1'b0 && model_err < 255) model_err++;
      end
    end
  end

  // One request through an empty pipeline, checking latency and result.
  task automatic xact(input vec_t v);
    logic got;
    got = 0;
    rsp_ready = 1;
    req_a = v.a; req_b = v.b; req_op = v.op; req_valid = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("xact_accept", got, 1);
    @(negedge clk);
    chk("lat_early", rsp_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", rsp_valid, 1);
    chk("xact_out", rsp_out, v.out);
    chk("xact_flags", {28'b0, rsp_overflow, rsp_zero, rsp_negative, rsp_err},
        {28'b0, v.ov, v.z, v.n, v.err});
    if (v.err && errs_seen < 255) errs_seen++;
    @(posedge clk); #1;
    chk("xact_errcnt", {24'b0, err_count}, errs_seen);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    tbl[0]  = '{32'd8,        32'd4,        ALU_ADD, 32'd12,       0, 0, 0, 0};
    tbl[1]  = '{32'd2,        32'd5,        ALU_SUB, 32'hFFFFFFFD, 0, 0, 1, 0};
    tbl[2]  = '{32'h80000000, 32'h80000000, ALU_ADD, 32'h0,        1, 1, 0, 0};
    tbl[3]  = '{32'hFF,       32'h0F,       ALU_AND, 32'h0F,       0, 0, 0, 0};
    tbl[4]  = '{32'hF0,       32'h0F,       ALU_OR,  32'hFF,       0, 0, 0, 0};
    tbl[5]  = '{32'h0,        32'h0,        ALU_NOR, 32'hFFFFFFFF, 0, 0, 1, 0};
    tbl[6]  = '{32'hAAAA5555, 32'hFFFF0000, ALU_XOR, 32'h5555_5555, 0, 0, 0, 0};
    tbl[7]  = '{32'h80000000, 32'h1,        ALU_SUB, 32'h7FFFFFFF, 1, 0, 0, 0};
    tbl[8]  = '{32'd5,        32'd5,        ALU_SUB, 32'h0,        0, 1, 0, 0};
    tbl[9]  = '{32'h7FFFFFFF, 32'h1,        ALU_ADD, 32'h80000000, 1, 0, 1, 0};
    tbl[10] = '{32'h1234,     32'h5678,     3'b101,  32'h0,        0, 0, 0, 1};
    tbl[11] = '{32'hFFFF,     32'h1,        3'b111,  32'h0,        0, 0, 0, 1};

    // Reset state.
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_out", rsp_out, 0);
    chk("rst_flags", {28'b0, rsp_overflow, rsp_zero, rsp_negative, rsp_err}, 0);
    chk("rst_errcnt", {24'b0, err_count}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1 chk("ready_after_rst", req_ready, 1);

    // Directed table.
    foreach (tbl[i]) xact(tbl[i]);

    // Illegal-op saturation.
    rsp_ready = 1; req_op = 3'b111; req_valid = 1;
    repeat (300) @(posedge clk);
    #1 req_valid = 0;
    repeat (4) @(posedge clk);
    #1 chk("errcnt_sat", {24'b0, err_count}, 255);

    // Reset with S1 and both FIFO entries full.
    rsp_ready = 0; req_op = ALU_ADD; req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      req_a = k; req_b = 32'd100;
      @(posedge clk); #1;
    end
    req_valid = 0;
    @(negedge clk);
    chk("full_ready", req_ready, 0);
    chk("full_valid", rsp_valid, 1);
    @(posedge clk); #1 reset = 0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_out", rsp_out, 0);
    chk("mid_rst_errcnt", {24'b0, err_count}, 0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1;
    errs_seen = 0;
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", rsp_valid, 0);
    xact('{32'hFF, 32'h0F, ALU_AND, 32'h0F, 0, 0, 0, 0});

    // Streaming: ten requests back to back.
    rsp_ready = 1; req_valid = 1;
    for (int k = 0; k < 10; k++) begin
      req_a = tbl[k].a; req_b = tbl[k].b; req_op = tbl[k].op;
      @(negedge clk);
      chk("stream_ready", req_ready, 1);
      chk("stream_valid", rsp_valid, (k >= 2));
      @(posedge clk); #1;
    end
    req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stream_tail", rsp_valid, (k < 2));
      @(posedge clk); #1;
    end

    // Backpressure: four requests against a stalled consumer.
    rsp_ready = 0; acc = 0;
    req_a = tbl[3].a; req_b = tbl[3].b; req_op = tbl[3].op; req_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
      if (acc < 4) begin
        req_a = tbl[3 + acc].a; req_b = tbl[3 + acc].b; req_op = tbl[3 + acc].op;
      end
    end
    chk("bp_accepted", acc, 3);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    @(posedge clk); #1 rsp_ready = 1;
    for (int c = 0; c < 8 && acc < 4; c++) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 0;
    chk("bp_fourth", acc, 4);
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_a = pick(); req_b = pick();
      req_op = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
